// File: rtl/suma_paso_fifo.sv
// suma_paso_fifo: streaming +STEP incrementer with carry/saturation flag and DEPTH-entry output FIFO
module suma_paso_fifo #(
    parameter int WIDTH    = 16,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b0,
    parameter int DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] tupla,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] respuesta,
    output logic             acarreo,
    output logic [WIDTH-1:0] n_desb
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [WIDTH:0]   mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] respuesta_q, respuesta_d;
    logic             acarreo_q, acarreo_d;
    logic [WIDTH-1:0] n_desb_q, n_desb_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   head;
    logic             push, pop;

    // Handshakes, arithmetic at push, and next-state of pointers, storage and the head-of-queue registers.
    // in_ready comes only from registered occupancy, so a pop while full cannot admit a push that cycle.
    always_comb begin
        push        = in_valid & in_ready_q;
        pop         = out_valid_q & out_ready;
        sum         = {1'b0, tupla} + STEP_W;
        res         = (SATURATE && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        mem_d       = mem_q;
        if (push) mem_d[wr_ptr_q] = {sum[WIDTH], res};
        head        = mem_d[rd_ptr_d];
        out_valid_d = cnt_d != '0;
        respuesta_d = out_valid_d ? head[WIDTH-1:0] : respuesta_q;
        acarreo_d   = out_valid_d ? head[WIDTH] : acarreo_q;
        in_ready_d  = cnt_d != FULL;
        n_desb_d    = n_desb_q + WIDTH'(push & sum[WIDTH]);
    end

    // Queue storage carries no reset: reset only needs to empty the queue, not clear its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state and registered outputs; reset discards everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            respuesta_q <= '0;
            acarreo_q   <= 1'b0;
            n_desb_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            respuesta_q <= respuesta_d;
            acarreo_q   <= acarreo_d;
            n_desb_q    <= n_desb_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign respuesta = respuesta_q;
    assign acarreo   = acarreo_q;
    assign n_desb    = n_desb_q;
endmodule

// File: tb/tb_suma_paso_fifo.sv
// tb_suma_paso_fifo: vector table, corner sequences and random traffic against a queue model
module tb_suma_paso_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] tupla = '0;
    logic in_ready, out_valid, acarreo;
    logic [15:0] respuesta, n_desb;

    logic a_v = 1'b0, a_r = 1'b0;
    logic [15:0] a16 = '0;
    logic [7:0] a8 = '0;
    logic s_ir, s_ov, s_c, w_ir, w_ov, w_c, z_ir, z_ov, z_c;
    logic [15:0] s_r, s_n;
    logic [7:0] w_r, w_n, z_r, z_n;

    always #5 clk = ~clk;

    suma_paso_fifo #(.WIDTH(16), .STEP(1), .SATURATE(1'b0), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .tupla(tupla),
        .out_valid(out_valid), .out_ready(out_ready), .respuesta(respuesta), .acarreo(acarreo), .n_desb(n_desb));
    suma_paso_fifo #(.WIDTH(16), .STEP(1), .SATURATE(1'b1), .DEPTH(4)) dut_s (
        .clk(clk), .reset(reset), .in_valid(a_v), .in_ready(s_ir), .tupla(a16),
        .out_valid(s_ov), .out_ready(a_r), .respuesta(s_r), .acarreo(s_c), .n_desb(s_n));
    suma_paso_fifo #(.WIDTH(8), .STEP(16), .SATURATE(1'b0), .DEPTH(4)) dut_w (
        .clk(clk), .reset(reset), .in_valid(a_v), .in_ready(w_ir), .tupla(a8),
        .out_valid(w_ov), .out_ready(a_r), .respuesta(w_r), .acarreo(w_c), .n_desb(w_n));
    suma_paso_fifo #(.WIDTH(8), .STEP(16), .SATURATE(1'b1), .DEPTH(4)) dut_z (
        .clk(clk), .reset(reset), .in_valid(a_v), .in_ready(z_ir), .tupla(a8),
        .out_valid(z_ov), .out_ready(a_r), .respuesta(z_r), .acarreo(z_c), .n_desb(z_n));

    typedef struct {
        logic [15:0] t;
        logic [15:0] r;
        logic        c;
    } vec_t;

    int nvec = 0, nerr = 0;
    logic [16:0] q[$];
    logic [16:0] last = '0;
    logic [15:0] ovf = '0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // One cycle at negedge: compare DUT with model, drive inputs, advance model, move to next negedge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic r);
        int s;
        logic psh, pp;
        in_valid = v;
        tupla = d;
        out_ready = r;
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("respuesta", respuesta, q[0][15:0]);
            chk("acarreo", acarreo, q[0][16]);
            last = q[0];
        end else begin
            chk("hold_respuesta", respuesta, last[15:0]);
            chk("hold_acarreo", acarreo, last[16]);
        end
        chk("in_ready", in_ready, q.size() < 4);
        chk("n_desb", n_desb, ovf);
        pp = q.size() != 0 && r;
        psh = v && q.size() < 4;
        if (pp) void'(q.pop_front());
        if (psh) begin
            s = int'(d) + 1;
            q.push_back(17'(s));
            if (s > 16'hFFFF) ovf++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() != 0; k++) cyc(1'b0, 16'h0, 1'b1);
    endtask

    vec_t tbl[18];
    int idx, got;
    logic ok;

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{16'(i * 16), 16'(i * 16 + 1), 1'b0};
        tbl[16] = '{16'hFFFF, 16'h0000, 1'b1};
        tbl[17] = '{16'hFFFE, 16'hFFFF, 1'b0};

        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_respuesta", respuesta, 0);
        chk("rst_acarreo", acarreo, 0);
        chk("rst_n_desb", n_desb, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Other parameterisations: one push each, then look at the head.
        a_v = 1'b1;
        a16 = 16'hFFFF;
        a8 = 8'hF5;
        @(posedge clk);
        @(negedge clk);
        a_v = 1'b0;
        chk("sat16_valid", s_ov, 1);
        chk("sat16_resp", s_r, 16'hFFFF);
        chk("sat16_carry", s_c, 1);
        chk("sat16_ndesb", s_n, 1);
        chk("w8_resp", w_r, 8'h05);
        chk("w8_carry", w_c, 1);
        chk("w8_ndesb", w_n, 1);
        chk("z8_resp", z_r, 8'hFF);
        chk("z8_carry", z_c, 1);

        // Table: push one word, see it next cycle, pop it.
        for (int i = 0; i < 18; i++) begin
            cyc(1'b1, tbl[i].t, 1'b0);
            chk("vec_valid", out_valid, 1);
            chk("vec_resp", respuesta, tbl[i].r);
            chk("vec_carry", acarreo, tbl[i].c);
            cyc(1'b0, 16'h0, 1'b1);
        end
        chk("vec_ndesb", n_desb, 1);
        cyc(1'b0, 16'h0, 1'b0);

        // Fill with consumer stalled, then release and collect in order.
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            ok = q.size() < 4;
            cyc(1'b1, 16'h0100 + 16'(idx), 1'b0);
            if (ok) idx++;
        end
        chk("full_accepted", idx, 4);
        chk("full_in_ready", in_ready, 0);
        got = 0;
        for (int k = 0; k < 30 && (idx < 6 || q.size() != 0); k++) begin
            if (q.size() != 0) begin
                chk("full_order", respuesta, 16'h0101 + 16'(got));
                got++;
            end
            ok = idx < 6 && q.size() < 4;
            cyc(idx < 6, 16'h0100 + 16'(idx), 1'b1);
            if (ok) idx++;
        end
        chk("full_delivered", got, 6);

        // Steady push+pop at two entries.
        drain();
        cyc(1'b1, 16'h2000, 1'b0);
        cyc(1'b1, 16'h2001, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("steady_valid", out_valid, 1);
            chk("steady_order", respuesta, 16'h2001 + 16'(k));
            cyc(1'b1, 16'h2002 + 16'(k), 1'b1);
        end
        chk("steady_in_ready", in_ready, 1);

        // Asynchronous reset with three results queued.
        drain();
        cyc(1'b1, 16'hFFFF, 1'b0);
        cyc(1'b1, 16'h0005, 1'b0);
        cyc(1'b1, 16'h0006, 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_ndesb", n_desb, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_respuesta", respuesta, 0);
        chk("arst_n_desb", n_desb, 0);
        chk("arst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        last = '0;
        ovf = '0;
        @(posedge clk);
        @(negedge clk);
        cyc(1'b1, 16'h1234, 1'b0);
        chk("post_rst_resp", respuesta, 16'h1235);
        cyc(1'b0, 16'h0, 1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++)
            cyc(($urandom % 4) != 0, ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom), ($urandom % 3) != 0);
        drain();
        cyc(1'b0, 16'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
